calc_execute_unit: RTL and testbench

- Arithmetic back end of the two-digit calculator. It sits directly downstream of the keypad/entry state machine.
- It consumes the packed 19-bit operand/operator buffer on a start pulse. It converts both BCD operands to binary, performs add, subtract or multiply, and converts the result back to four BCD digits.
- The BCD digits drive the seven-segment stage (4'hF means blank digit).

---
 rtl/calc_execute_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_calc_execute_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/calc_execute_unit.sv
// Calculator arithmetic back end: BCD operands -> add/sub/shift-add multiply -> double-dabble -> BCD digits.
// Latency from the start edge to o_Done: add/sub 16, multiply 22, error 2. i_Start is ignored while busy.
module calc_execute_unit #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [18:0] i_Operands,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [15:0] o_Result_BCD,
    output logic        o_Negative,
    output logic        o_Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_COMPUTE,
        S_CONVERT,
        S_DONE
    } state_t;

    localparam logic [2:0]  OP_ADD = 3'b001;
    localparam logic [2:0]  OP_SUB = 3'b010;
    localparam logic [2:0]  OP_MUL = 3'b011;
    localparam logic [15:0] RESULT_RST = BLANK_LEADING ? 16'hFFF0 : 16'h0000;

    state_t      state;
    state_t      state_next;

    logic [18:0] opr;
    logic        err_pend;
    logic        neg_pend;
    logic [6:0]  a_bin;
    logic [6:0]  b_bin;
    logic [13:0] prod;
    logic [13:0] mcand;
    logic [6:0]  mplier;
    logic [3:0]  cnt;
    logic [15:0] dd_bcd;
    logic [13:0] dd_bin;

    logic [3:0]  a_tens;
    logic [3:0]  a_ones;
    logic [3:0]  b_tens;
    logic [3:0]  b_ones;
    logic [2:0]  op;
    logic        req_ok;
    logic [6:0]  a_val;
    logic [6:0]  b_val;
    logic [13:0] prod_next;
    logic [15:0] dd_adj;
    logic [15:0] bcd_next;
    logic [13:0] bin_next;

    assign a_tens = opr[18:15];
    assign a_ones = opr[14:11];
    assign op     = opr[10:8];
    assign b_tens = opr[7:4];
    assign b_ones = opr[3:0];

    assign req_ok = (a_tens <= 4'd9) && (a_ones <= 4'd9) &&
                    (b_tens <= 4'd9) && (b_ones <= 4'd9) &&
                    ((op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL));

    // 10*x as (x<<3)+(x<<1) keeps the decode free of multipliers.
    assign a_val = ({3'b000, a_tens} << 3) + ({3'b000, a_tens} << 1) + {3'b000, a_ones};
    assign b_val = ({3'b000, b_tens} << 3) + ({3'b000, b_tens} << 1) + {3'b000, b_ones};

    assign prod_next = prod + (mplier[0] ? mcand : 14'd0);

    always_comb begin
        dd_adj = dd_bcd;
        for (int i = 0; i < 4; i++) begin
            if (dd_bcd[i*4 +: 4] >= 4'd5) begin
                dd_adj[i*4 +: 4] = dd_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign bcd_next = {dd_adj[14:0], dd_bin[13]};
    assign bin_next = {dd_bin[12:0], 1'b0};

    function automatic logic [15:0] blank_digits(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (BLANK_LEADING) begin
            if (d[15:12] == 4'd0) begin
                r[15:12] = 4'hF;
                if (d[11:8] == 4'd0) begin
                    r[11:8] = 4'hF;
                    if (d[7:4] == 4'd0) begin
                        r[7:4] = 4'hF;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Rejected requests pass once through COMPUTE so every exit to DONE happens from a registered decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_Start) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (err_pend) begin
                    state_next = S_DONE;
                end else if ((op != OP_MUL) || (cnt == 4'd6)) begin
                    state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt == 4'd13) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            opr          <= 19'd0;
            err_pend     <= 1'b0;
            neg_pend     <= 1'b0;
            a_bin        <= 7'd0;
            b_bin        <= 7'd0;
            prod         <= 14'd0;
            mcand        <= 14'd0;
            mplier       <= 7'd0;
            cnt          <= 4'd0;
            dd_bcd       <= 16'd0;
            dd_bin       <= 14'd0;
            o_Result_BCD <= RESULT_RST;
            o_Negative   <= 1'b0;
            o_Error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        opr <= i_Operands;
                    end
                end
                S_DECODE: begin
                    err_pend <= !req_ok;
                    neg_pend <= 1'b0;
                    a_bin    <= a_val;
                    b_bin    <= b_val;
                    prod     <= 14'd0;
                    mcand    <= {7'd0, a_val};
                    mplier   <= b_val;
                    cnt      <= 4'd0;
                end
                S_COMPUTE: begin
                    if (err_pend) begin
                        o_Result_BCD <= blank_digits(16'd0);
                        o_Negative   <= 1'b0;
                        o_Error      <= 1'b1;
                    end else if (op == OP_MUL) begin
                        prod   <= prod_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 4'd1;
                        if (cnt == 4'd6) begin
                            dd_bin <= prod_next;
                            dd_bcd <= 16'd0;
                            cnt    <= 4'd0;
                        end
                    end else if (op == OP_SUB) begin
                        dd_bcd <= 16'd0;
                        cnt    <= 4'd0;
                        if (a_bin < b_bin) begin
                            dd_bin   <= {7'd0, b_bin - a_bin};
                            neg_pend <= 1'b1;
                        end else begin
                            dd_bin   <= {7'd0, a_bin - b_bin};
                        end
                    end else begin
                        dd_bin <= {7'd0, a_bin} + {7'd0, b_bin};
                        dd_bcd <= 16'd0;
                        cnt    <= 4'd0;
                    end
                end
                S_CONVERT: begin
                    dd_bcd <= bcd_next;
                    dd_bin <= bin_next;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        o_Result_BCD <= blank_digits(bcd_next);
                        o_Negative   <= neg_pend;
                        o_Error      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_Busy = (state != S_IDLE);
    assign o_Done = (state == S_DONE);

endmodule

// File: tb/tb_calc_execute_unit.sv
// Directed bench for calc_execute_unit: hand-computed results, latencies, busy/done timing and reset abort.
module tb_calc_execute_unit;

    logic        i_Clk;
    logic        i_Reset;
    logic        i_Start;
    logic [18:0] i_Operands;
    logic        o_Busy;
    logic        o_Done;
    logic [15:0] o_Result_BCD;
    logic        o_Negative;
    logic        o_Error;

    int n_tests = 0;
    int n_fail  = 0;

    calc_execute_unit #(.BLANK_LEADING(1'b1)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Start      (i_Start),
        .i_Operands   (i_Operands),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Result_BCD (o_Result_BCD),
        .o_Negative   (o_Negative),
        .o_Error      (o_Error)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    function automatic logic [18:0] mk(input logic [3:0] at, input logic [3:0] ao,
                                       input logic [2:0] op, input logic [3:0] bt,
                                       input logic [3:0] bo);
        return {at, ao, op, bt, bo};
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start (edge 0), count edges until o_Done, check the result, then the return to IDLE.
    task automatic do_op(input string tag, input logic [18:0] opr, input int exp_lat,
                         input logic [15:0] exp_res, input logic exp_neg, input logic exp_err);
        int lat;
        int busy_low;
        i_Operands = opr;
        i_Start    = 1'b1;
        tick();
        i_Start    = 1'b0;
        lat        = 0;
        busy_low   = (o_Busy === 1'b1) ? 0 : 1;
        while (o_Done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
            if (o_Busy !== 1'b1) busy_low++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_gaps"}, busy_low, 0);
        chk({tag, " result"}, {16'd0, o_Result_BCD}, {16'd0, exp_res});
        chk({tag, " negative"}, {31'd0, o_Negative}, {31'd0, exp_neg});
        chk({tag, " error"}, {31'd0, o_Error}, {31'd0, exp_err});
        tick();
        chk({tag, " idle_busy"}, {31'd0, o_Busy}, 32'd0);
        chk({tag, " idle_done"}, {31'd0, o_Done}, 32'd0);
    endtask

    initial begin
        int first_done;
        int n_done;
        int stray;

        i_Reset    = 1'b1;
        i_Start    = 1'b0;
        i_Operands = '0;
        tick();
        tick();
        i_Reset = 1'b0;
        chk("rst busy", {31'd0, o_Busy}, 32'd0);
        chk("rst done", {31'd0, o_Done}, 32'd0);
        chk("rst result", {16'd0, o_Result_BCD}, 32'h0000FFF0);
        chk("rst negative", {31'd0, o_Negative}, 32'd0);
        chk("rst error", {31'd0, o_Error}, 32'd0);
        tick();

        do_op("add 12+34", mk(4'd1, 4'd2, 3'b001, 4'd3, 4'd4), 16, 16'hFF46, 1'b0, 1'b0);
        do_op("add 99+99", mk(4'd9, 4'd9, 3'b001, 4'd9, 4'd9), 16, 16'hF198, 1'b0, 1'b0);
        do_op("mul 99x99", mk(4'd9, 4'd9, 3'b011, 4'd9, 4'd9), 22, 16'h9801, 1'b0, 1'b0);
        do_op("mul 00x57", mk(4'd0, 4'd0, 3'b011, 4'd5, 4'd7), 22, 16'hFFF0, 1'b0, 1'b0);
        do_op("mul 10x10", mk(4'd1, 4'd0, 3'b011, 4'd1, 4'd0), 22, 16'hF100, 1'b0, 1'b0);
        do_op("sub 05-12", mk(4'd0, 4'd5, 3'b010, 4'd1, 4'd2), 16, 16'hFFF7, 1'b1, 1'b0);
        do_op("sub 12-05", mk(4'd1, 4'd2, 3'b010, 4'd0, 4'd5), 16, 16'hFFF7, 1'b0, 1'b0);
        do_op("sub 99-99", mk(4'd9, 4'd9, 3'b010, 4'd9, 4'd9), 16, 16'hFFF0, 1'b0, 1'b0);
        do_op("err tensA", mk(4'hA, 4'd1, 3'b001, 4'd0, 4'd1), 2, 16'hFFF0, 1'b0, 1'b1);
        do_op("add 01+01", mk(4'd0, 4'd1, 3'b001, 4'd0, 4'd1), 16, 16'hFFF2, 1'b0, 1'b0);
        do_op("sub 01-09", mk(4'd0, 4'd1, 3'b010, 4'd0, 4'd9), 16, 16'hFFF8, 1'b1, 1'b0);
        do_op("err op111", mk(4'd1, 4'd1, 3'b111, 4'd1, 4'd1), 2, 16'hFFF0, 1'b0, 1'b1);
        do_op("err op000", mk(4'd1, 4'd1, 3'b000, 4'd1, 4'd1), 2, 16'hFFF0, 1'b0, 1'b1);
        do_op("err onesB", mk(4'd1, 4'd1, 3'b011, 4'd1, 4'hF), 2, 16'hFFF0, 1'b0, 1'b1);

        // 23x45 = 1035 while operands change and start is re-pulsed during the operation.
        i_Operands = mk(4'd2, 4'd3, 3'b011, 4'd4, 4'd5);
        i_Start    = 1'b1;
        tick();
        i_Start    = 1'b0;
        first_done = 0;
        n_done     = 0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3) i_Operands = mk(4'd7, 4'd7, 3'b001, 4'd1, 4'd1);
            if (e == 5 || e == 16) begin
                i_Operands = mk(4'd1, 4'd1, 3'b001, 4'd1, 4'd1);
                i_Start    = 1'b1;
            end
            tick();
            i_Start = 1'b0;
            if (o_Done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = e;
                chk("ignore result", {16'd0, o_Result_BCD}, 32'h00001035);
            end
        end
        chk("ignore done_edge", first_done, 22);
        chk("ignore done_count", n_done, 1);
        chk("ignore busy_after", {31'd0, o_Busy}, 32'd0);
        chk("ignore error", {31'd0, o_Error}, 32'd0);

        do_op("sub 01-02", mk(4'd0, 4'd1, 3'b010, 4'd0, 4'd2), 16, 16'hFFF1, 1'b1, 1'b0);

        // Abort a 99x99 with reset at edge 12; the next start follows immediately.
        i_Operands = mk(4'd9, 4'd9, 3'b011, 4'd9, 4'd9);
        i_Start    = 1'b1;
        tick();
        i_Start = 1'b0;
        stray   = 0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (o_Done === 1'b1) stray++;
        end
        chk("abort prebusy", {31'd0, o_Busy}, 32'd1);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("abort stray_done", stray, 0);
        chk("abort busy", {31'd0, o_Busy}, 32'd0);
        chk("abort done", {31'd0, o_Done}, 32'd0);
        chk("abort result", {16'd0, o_Result_BCD}, 32'h0000FFF0);
        chk("abort negative", {31'd0, o_Negative}, 32'd0);
        chk("abort error", {31'd0, o_Error}, 32'd0);
        do_op("post-abort 02+03", mk(4'd0, 4'd2, 3'b001, 4'd0, 4'd3), 16, 16'hFFF5, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
